// File: rtl/bch_pkg.sv
// Shared BCH(63,51) constants and types for the decoder and its downstream blocks.
package bch_pkg;

  localparam int BCH_N      = 63;
  localparam int BCH_K      = 51;
  localparam int BCH_PARITY = BCH_N - BCH_K;

  typedef logic [5:0] bit_idx_t;

endpackage

// File: rtl/bch_bit_packer.sv
// Generic serial-to-parallel packer, MSB first, with a single holding register.
// Word visible the cycle after its last bit; holding register reloads and can be drained in the same cycle.
module bch_bit_packer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         bit_vld,
  input  logic         bit_dat,
  input  logic         payload_en,
  input  logic         out_ready,
  output logic         acc_last,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-2:0]  acc;
  logic [CW-1:0] acc_cnt;
  logic          shift;
  logic          complete;

  assign shift    = bit_vld && payload_en;
  assign acc_last = (acc_cnt == LAST);
  assign complete = shift && acc_last;

  // clr drops a partial word but never touches a word already in the holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (clr) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (shift) begin
      acc     <= {acc[W-3:0], bit_dat};
      acc_cnt <= complete ? '0 : acc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_data  <= {acc, bit_dat};
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bch_payload_packer.sv
// Strips BCH parity from the corrected serial codeword stream and packs payload bits into W-bit words.
// Input stalls only when a word-completing payload bit meets a full, undrained holding register.
module bch_payload_packer
  import bch_pkg::*;
#(
  parameter int N = BCH_N,
  parameter int K = BCH_K,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         resync,
  input  logic         in_valid,
  input  logic         in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  localparam int            BW       = $clog2(N);
  localparam logic [BW-1:0] K_IDX    = BW'(K);
  localparam logic [BW-1:0] LAST_IDX = BW'(N - 1);

  logic [BW-1:0] bit_cnt;
  logic          payload;
  logic          acc_last;
  logic          xfer;

  assign payload  = (bit_cnt < K_IDX);
  assign in_ready = !(out_valid && !out_ready && acc_last && payload);
  assign xfer     = in_valid && in_ready;

  // resync wins over a same-cycle transfer; that bit is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (resync) begin
      bit_cnt <= '0;
    end else if (xfer) begin
      bit_cnt <= (bit_cnt == LAST_IDX) ? '0 : bit_cnt + 1'b1;
    end
  end

  bch_bit_packer #(
    .W (W)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (resync),
    .bit_vld    (xfer && !resync),
    .bit_dat    (in_data),
    .payload_en (payload),
    .out_ready  (out_ready),
    .acc_last   (acc_last),
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

endmodule

// File: tb/tb_bch_payload_packer.sv
// Bench for bch_payload_packer: directed scenarios plus randomized traffic against a bit-stream model.
module tb_bch_payload_packer;

  localparam logic [62:0] CW = 63'b1000_0100_1010_1111_0110_1000_0110_1000_0010_0101_1010_1010_1101_1000_0000_110;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       resync    = 1'b0;
  logic       in_valid  = 1'b0;
  logic       in_data   = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: position in codeword, pending payload bits, holding register
  int         m_pos    = 0;
  logic       m_part[$];
  bit         m_hold_v = 1'b0;
  logic [7:0] m_hold_d = 8'h00;
  logic [7:0] got_q[$];

  bch_payload_packer #(.N(63), .K(51), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .resync    (resync),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Inputs only change just after a rising edge, so the negedge view is what the next edge will see.
  always @(negedge clk) begin
    bit         exp_rdy;
    bit         done;
    logic [7:0] w;
    w    = 8'h00;
    done = 1'b0;
    if (rst) begin
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL mon_in_reset: out_valid=%b in_ready=%b, required 0/1 at %0t", out_valid, in_ready, $time);
      end
      m_pos = 0;
      m_part.delete();
      m_hold_v = 1'b0;
      m_hold_d = 8'h00;
    end else begin
      exp_rdy = !(m_hold_v && !out_ready && m_pos < 51 && m_part.size() == 7);
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL mon_in_ready: got %b, required %b at %0t", in_ready, exp_rdy, $time);
      end
      n_cmp++;
      if (out_valid !== m_hold_v) begin
        n_err++;
        $display("FAIL mon_out_valid: got %b, required %b at %0t", out_valid, m_hold_v, $time);
      end
      if (m_hold_v) begin
        n_cmp++;
        if (out_data !== m_hold_d) begin
          n_err++;
          $display("FAIL mon_out_data: got %h, required %h at %0t", out_data, m_hold_d, $time);
        end
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (resync) begin
        m_pos = 0;
        m_part.delete();
      end else if (in_valid && exp_rdy) begin
        if (m_pos < 51) begin
          m_part.push_back(in_data);
          if (m_part.size() == 8) begin
            foreach (m_part[i]) w = {w[6:0], m_part[i]};
            m_part.delete();
            done = 1'b1;
          end
        end
        m_pos = (m_pos + 1) % 63;
      end
      if (done) begin
        m_hold_v = 1'b1;
        m_hold_d = w;
      end else if (m_hold_v && out_ready) begin
        m_hold_v = 1'b0;
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; resync = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete();
  endtask

  task automatic send_bit(input logic b, output bit ok);
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 64 cycles at %0t", $time);
    end
  endtask

  task automatic send_range(input logic [62:0] cw, input int first, input int last);
    bit ok;
    for (int i = first; i <= last; i++) send_bit(cw[62-i], ok);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: out_valid=%b in_ready=%b out_data=%h, required 0/1/00", out_valid, in_ready, out_data);
    end
    apply_reset();
    n_cmp++;
    if (dut.u_packer.acc_cnt !== 3'd0 || dut.bit_cnt !== 6'd0) begin
      n_err++;
      $display("FAIL reset_counters: acc_cnt=%0d bit_cnt=%0d, required 0/0", dut.u_packer.acc_cnt, dut.bit_cnt);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_w [6] = '{8'h84, 8'hAF, 8'h68, 8'h68, 8'h25, 8'hAA};
    apply_reset();
    out_ready = 1'b1;
    send_range(CW, 0, 62);
    @(posedge clk); #1;
    n_cmp++;
    if (got_q.size() != 6) begin
      n_err++;
      $display("FAIL single_count: got %0d words, required 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (got_q[i] !== exp_w[i]) begin
          n_err++;
          $display("FAIL single_word%0d: got %h, required %h", i, got_q[i], exp_w[i]);
        end
      end
    end
    n_cmp++;
    if (dut.u_packer.acc_cnt !== 3'd3) begin
      n_err++;
      $display("FAIL single_residual: acc_cnt=%0d, required 3", dut.u_packer.acc_cnt);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) send_range(CW, 0, 62);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (got_q.size() != 51) begin
      n_err++;
      $display("FAIL b2b_count: got %0d words, required 51", got_q.size());
    end
    if (got_q.size() > 6) begin
      n_cmp++;
      if (got_q[6] !== 8'hD0) begin
        n_err++;
        $display("FAIL b2b_word6: got %h, required d0", got_q[6]);
      end
    end
    n_cmp++;
    if (dut.u_packer.acc_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL b2b_residual: acc_cnt=%0d, required 0", dut.u_packer.acc_cnt);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    out_ready = 1'b0;
    send_range(CW, 0, 14);
    in_valid = 1'b1;
    in_data  = CW[62-15];
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h84) begin
      n_err++;
      $display("FAIL stall_hold: in_ready=%b out_valid=%b out_data=%h, required 0/1/84", in_ready, out_valid, out_data);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hAF) begin
      n_err++;
      $display("FAIL no_bubble: out_valid=%b out_data=%h, required 1/af", out_valid, out_data);
    end
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== 8'h84 || got_q[1] !== 8'hAF) begin
      n_err++;
      $display("FAIL stall_words: got %0d words, required 84 then af", got_q.size());
    end
  endtask

  task automatic test_resync();
    logic [7:0] exp_w [8] = '{8'h84, 8'hAF, 8'h84, 8'hAF, 8'h68, 8'h68, 8'h25, 8'hAA};
    apply_reset();
    out_ready = 1'b1;
    send_range(CW, 0, 19);
    resync   = 1'b1;
    in_valid = 1'b1;
    in_data  = 1'b1;
    @(posedge clk); #1;
    resync   = 1'b0;
    in_valid = 1'b0;
    send_range(CW, 0, 62);
    @(posedge clk); #1;
    n_cmp++;
    if (got_q.size() != 8) begin
      n_err++;
      $display("FAIL resync_count: got %0d words, required 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (got_q[i] !== exp_w[i]) begin
          n_err++;
          $display("FAIL resync_word%0d: got %h, required %h", i, got_q[i], exp_w[i]);
        end
      end
    end
    n_cmp++;
    if (dut.u_packer.acc_cnt !== 3'd3) begin
      n_err++;
      $display("FAIL resync_residual: acc_cnt=%0d, required 3", dut.u_packer.acc_cnt);
    end
  endtask

  task automatic test_rst_mid();
    apply_reset();
    out_ready = 1'b1;
    send_range(CW, 0, 23);
    out_ready = 1'b0;
    send_range(CW, 24, 29);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h68) begin
      n_err++;
      $display("FAIL rstmid_pending: out_valid=%b out_data=%h, required 1/68", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_clear: out_valid=%b in_ready=%b out_data=%h, required 0/1/00", out_valid, in_ready, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    got_q.delete();
    send_range(CW, 0, 62);
    n_cmp++;
    if (got_q.size() != 6 || got_q[0] !== 8'h84) begin
      n_err++;
      $display("FAIL rstmid_restart: got %0d words first %h, required 6 words first 84", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_random();
    int err0;
    apply_reset();
    err0 = n_err;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 1'($urandom_range(1));
      out_ready = ($urandom_range(2) != 0);
      resync    = ($urandom_range(96) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    resync   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (got_q.size() < 100) begin
      n_err++;
      $display("FAIL random_throughput: got %0d words, required at least 100", got_q.size());
    end
    if (n_err != err0) $display("random section reported %0d errors", n_err - err0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_resync();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bch_payload_packer.md
# bch_payload_packer

Downstream neighbour of the serial BCH(63,51) double-error-correcting decoder. Accepts the decoder's corrected bit-serial codeword stream (MSB first, systematic: 51 payload bits then 12 parity bits), discards the parity bits, and packs the payload bits MSB-first into W-bit words for the byte-oriented sink. Words span codeword boundaries because 51 is not a multiple of W. A resync input realigns the codeword bit counter to the upstream frame boundary.

## Interface
- `N`, 63: codeword length in bits.
- `K`, 51: payload bits per codeword; bits K..N-1 of each codeword are parity.
- `W`, 8: output word width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `resync`  in  1  one-cycle pulse; next accepted bit is codeword bit 0.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  1  corrected codeword bit, MSB (bit 0) first.
- `in_ready`  out  1  block can accept `in_data` this cycle.
- `out_valid`  out  1  `out_data` holds a complete word.
- `out_data`  out  W  packed payload word; first received bit in MSB.
- `out_ready`  in  1  sink accepts `out_data`.

## Operation
- A bit is transferred when `in_valid && in_ready` at a rising edge.
- `bit_cnt` (width clog2(N)) counts accepted bits 0..N-1 and wraps N-1 -> 0.
- When `bit_cnt < K`, the accepted bit is payload. It shifts into accumulator `acc` (W-1 bits) and increments `acc_cnt` (0..W-1).
- When `bit_cnt >= K`, the accepted bit is parity. It is consumed and dropped; `acc` and `acc_cnt` are unchanged.
- Completion: a payload bit is accepted while `acc_cnt == W-1`.
  - `{acc, in_data}` loads into the `out_data` holding register and `out_valid` is set.
  - `acc_cnt` returns to 0.
- `out_valid` clears when `out_valid && out_ready` and no completion occurs in the same cycle.
- Completion and output acceptance in the same cycle: the holding register reloads and `out_valid` stays 1, with no bubble.
- `in_ready = !(out_valid && !out_ready && acc_cnt == W-1 && bit_cnt < K)`.
  - This is combinational from `out_ready`.
  - Parity bits and non-completing payload bits are always accepted.
- `resync` (takes priority over a same-cycle transfer, whose bit is dropped):
  - clears `bit_cnt`, `acc_cnt` and `acc`, discarding any partial word;
  - leaves a pending `out_valid` word intact.
- Arithmetic: `bit_cnt` and `acc_cnt` are unsigned. The compare is `bit_cnt < K` with `K` cast to the `bit_cnt` width.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `in_ready` = 1.
  - Internal: `bit_cnt` = 0, `acc_cnt` = 0, `acc` = 0.
- Latency: the W-th payload bit is accepted at edge t; `out_valid`/`out_data` are valid after edge t (visible in cycle t+1).
- Throughput: 1 input bit per cycle. Per codeword: 63 cycles, 51/W words.
- Back-pressure only stalls the input at a word-completing payload bit.
- Reset asserted mid-codeword or with a pending word:
  - all state clears immediately;
  - the pending word is lost;
  - the first bit after reset release is codeword bit 0.
- `out_data` is stable while `out_valid && !out_ready`.

## Structure
- Shared package `bch_pkg`:
  - `BCH_N` = 63, `BCH_K` = 51, `BCH_PARITY` = 12;
  - `bit_idx_t` = logic [5:0].
- Both the decoder and this block use the package.
- One natural sub-module, `bch_bit_packer`:
  - generic W-bit serial-to-parallel packer with the holding register and valid/ready;
  - instantiated with a payload-enable input driven by `bit_cnt < K`.
- This block owns `bit_cnt`, resync and the ready gating.

## Test plan
- Single codeword 63'b1000_0100_1010_1111_0110_1000_0110_1000_0010_0101_1010_1010_1101_1000_0000_110, `out_ready`=1 -> words 0x84, 0xAF, 0x68, 0x68, 0x25, 0xAA. Residual `acc_cnt`=3, parity ignored.
- Same codeword twice back-to-back -> 7th word 0xD0 (residual 110 + 10000). After 8 codewords (408 bits) exactly 51 words and `acc_cnt`=0.
- `out_ready` held 0 after the first word -> `in_ready` drops only at the 16th payload bit. `out_data` holds 0x84. Releasing `out_ready` accepts the stalled bit next edge, then 0xAF.
- Completion coincides with `out_ready`=1 -> `out_valid` stays high and the next word appears with no gap.
- `resync` at bit 20 of a codeword -> partial word (4 bits) discarded. The next 63 bits are treated as a fresh codeword: first word is the first 8 bits of that stream.
- `rst` asserted at bit 30 with `out_valid`=1 -> `out_valid`=0 and `in_ready`=1 immediately. The following codeword reproduces 0x84 first.
